alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at clk edge.
REQ-005 cmd_op  input  2  00 LOAD, 01 EXEC, 10 MUL, 11 CLR.
REQ-006 cmd_fs  input  3  ALU function select for EXEC; ignored otherwise.
REQ-007 cmd_data  input  4  operand (B for EXEC, multiplier for MUL, value for LOAD).
REQ-008 alu_a / alu_b  output  4 each  registered operands driven to ALU.
REQ-009 alu_fs  output  3  registered function select driven to ALU.
REQ-010 alu_y  input  4;  alu_c, alu_v, alu_n, alu_z  input  1 each  ALU result and flags, combinational from alu_a/alu_b/alu_fs.
REQ-011 rsp_valid  output  1;  rsp_ready  input  1  response handshake, transfer on both high.
REQ-012 rsp_data  output  8  result; {4'h0, acc} except MUL = full product.
REQ-013 rsp_flags  output  4  {C,V,N,Z}.
REQ-014 rsp_err  output  1  command unsupported.

Function
REQ-015 SHALL implement FSM IDLE, EXEC, MUL, RESP; cmd_ready = 1 only in IDLE.
REQ-016 IDLE: on accept, LOAD/CLR update acc (cmd_data / 0), flags = {0,0,acc_new[3],acc_new==0}, go RESP; EXEC drives alu_a=acc, alu_b=cmd_data, alu_fs=cmd_fs, go EXEC; MUL goes MUL.
REQ-017 EXEC: lasts exactly one cycle; at its end acc <= alu_y, flags <= {alu_c,alu_v,alu_n,alu_z}; go RESP. Accept-to-rsp_valid latency = 2 cycles.
REQ-018 MUL: shift-add, multiplicand = acc, multiplier = cmd_data held in mq; hi initialised 0; 4 iteration cycles, counter 0..3.
REQ-019 Each MUL iteration: alu_fs=3'b000, alu_a=hi, alu_b = mq[0] ? multiplicand : 4'h0; then {hi,mq} <= {alu_c, alu_y, mq[3:1]}.
REQ-020 After iteration 3: rsp_data={hi,mq}, acc <= mq (low nibble), flags = {0,0,hi[3],{hi,mq}==0}, go RESP; latency accept-to-rsp_valid = 5 cycles.
REQ-021 RESP: rsp_valid=1, rsp_data/flags/err stable until rsp_ready; on handshake go IDLE same edge, rsp_valid low next cycle.
REQ-022 rsp_ready held low: SHALL stall indefinitely in RESP, no new command accepted.
REQ-023 alu_a/alu_b/alu_fs SHALL hold last driven values outside EXEC/MUL.
REQ-024 rsp_err=1 only for unsupported op (see REQ-029); 0 otherwise.

Reset
REQ-025 rst_n low asynchronously forces IDLE, acc=0, hi=mq=0, counter=0, flags=0, alu_a=alu_b=0, alu_fs=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0 while asserted.
REQ-026 Reset mid-EXEC/MUL/RESP SHALL abort operation; no response emitted after release.
REQ-027 cmd_ready SHALL assert the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined: MUL implemented per REQ-018..020.
REQ-029 Macro absent: MUL logic omitted; MUL command goes straight to RESP with rsp_err=1, rsp_data={4'h0,acc}, acc and flags unchanged, latency 1 cycle.

Structure
REQ-030 Shared package alu_seq_pkg SHALL hold op encodings, state enum, FS constants (FS_ADD=3'b000, FS_SUB=3'b001), widths (DW=4).
REQ-031 One sub-module alu_seq_mul SHALL hold hi/mq/counter datapath; compiled only under ALU_SEQ_MUL_EN.
REQ-032 ALU itself is external; alu_sequencer SHALL not instantiate it.

Verification
REQ-033 Reset then LOAD 4'h5 -> rsp_valid after 1 cycle, rsp_data=8'h05, rsp_flags=4'b0000.
REQ-034 LOAD 4'h7, EXEC FS_ADD data 4'h1 with reference ALU model -> rsp_data=8'h08, flags V=1, N=1, C=0, Z=0 at cycle 2.
REQ-035 LOAD 4'hF, MUL data 4'hF (macro on) -> rsp_data=8'hE1 at cycle 5; macro off -> rsp_err=1, rsp_data=8'h0F at cycle 1.
REQ-036 rsp_ready low 10 cycles during RESP -> outputs stable, cmd_ready=0, single transfer on release.
REQ-037 rst_n pulsed low during MUL iteration 2 -> all outputs to reset values immediately, no rsp_valid afterwards, next LOAD works.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings, state enum and widths for the ALU sequencer.
// Included by alu_sequencer and alu_seq_mul (ALU_SEQ_MUL_EN builds only).
package alu_seq_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_EXEC = 2'b01,
    OP_MUL  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } state_e;

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;

  // {C,V,N,Z} for results that are loaded rather than computed
  function automatic logic [3:0] nz_flags(input logic [DW-1:0] v);
    return {2'b00, v[DW-1], (v == {DW{1'b0}})};
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier state (hi/mq/counter) stepped once per cycle by the sequencer.
// Built only when ALU_SEQ_MUL_EN is defined; the adder is the external ALU.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   alu_y,
  input  logic            alu_c,
  output logic [DW-1:0]   hi_nxt,
  output logic [DW-1:0]   mq_nxt,
  output logic [2*DW-1:0] prod,
  output logic            last
);

  logic [DW-1:0] hi;
  logic [DW-1:0] mq;
  logic [1:0]    cnt;

  // One right shift of {carry, sum, mq} per iteration
  assign hi_nxt = {alu_c, alu_y[DW-1:1]};
  assign mq_nxt = {alu_y[0], mq[DW-1:1]};
  assign prod   = {hi, mq};
  assign last   = step && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi  <= '0;
      mq  <= '0;
      cnt <= '0;
    end else if (start) begin
      hi  <= '0;
      mq  <= multiplier;
      cnt <= '0;
    end else if (step) begin
      hi  <= hi_nxt;
      mq  <= mq_nxt;
      cnt <= cnt + 2'd1;
    end
  end

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Accumulator sequencer driving an external ALU: LOAD/CLR/EXEC/MUL commands, one response each.
// MUL is shift-add over 4 cycles when ALU_SEQ_MUL_EN is defined, otherwise answered with rsp_err.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_fs,
  input  logic [DW-1:0] cmd_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_fs,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [3:0]    rsp_flags,
  output logic          rsp_err
);

  state_e        state, state_n;
  op_e           op;
  logic          armed;
  logic          accept;
  logic [DW-1:0] acc;
  logic [7:0]    rsp_word;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;

`ifdef ALU_SEQ_MUL_EN
  logic            mul_start, mul_step, mul_last, rsp_from_mul;
  logic [DW-1:0]   hi_nxt, mq_nxt;
  logic [2*DW-1:0] mul_prod;

  alu_seq_mul u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .step      (mul_step),
    .multiplier(cmd_data),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .hi_nxt    (hi_nxt),
    .mq_nxt    (mq_nxt),
    .prod      (mul_prod),
    .last      (mul_last)
  );

  // The product stays in hi/mq during RESP rather than being copied out
  assign rsp_data = rsp_from_mul ? mul_prod : rsp_word;
`else
  assign rsp_data = rsp_word;
`endif

  // armed keeps cmd_ready low through reset and releases it one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
    mul_step  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cmd_ready = armed;
        if (cmd_valid && armed) begin
          case (op)
            OP_EXEC: state_n = ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              state_n   = ST_MUL;
              mul_start = 1'b1;
            end
`endif
            default: state_n = ST_RESP;
          endcase
        end
      end
      ST_EXEC: state_n = ST_RESP;
      ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        mul_step = 1'b1;
        if (mul_last) state_n = ST_RESP;
`else
        state_n = ST_IDLE;
`endif
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fs    <= '0;
      rsp_word  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      rsp_from_mul <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          rsp_from_mul <= 1'b0;
`endif
          case (op)
            OP_LOAD: begin
              acc       <= cmd_data;
              rsp_word  <= {{DW{1'b0}}, cmd_data};
              rsp_flags <= nz_flags(cmd_data);
              rsp_err   <= 1'b0;
            end
            OP_CLR: begin
              acc       <= '0;
              rsp_word  <= '0;
              rsp_flags <= nz_flags({DW{1'b0}});
              rsp_err   <= 1'b0;
            end
            OP_EXEC: begin
              alu_a  <= acc;
              alu_b  <= cmd_data;
              alu_fs <= cmd_fs;
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              // Preload iteration 0 operands: hi starts at zero
              alu_a  <= '0;
              alu_b  <= cmd_data[0] ? acc : '0;
              alu_fs <= FS_ADD;
`else
              rsp_word <= {{DW{1'b0}}, acc};
              rsp_err  <= 1'b1;
`endif
            end
          endcase
        end
        ST_EXEC: begin
          acc       <= alu_y;
          rsp_word  <= {{DW{1'b0}}, alu_y};
          rsp_flags <= {alu_c, alu_v, alu_n, alu_z};
          rsp_err   <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mul_last) begin
            acc          <= mq_nxt;
            rsp_flags    <= {2'b00, hi_nxt[DW-1], ({hi_nxt, mq_nxt} == '0)};
            rsp_err      <= 1'b0;
            rsp_from_mul <= 1'b1;
          end else begin
            // Registered ALU inputs run one iteration ahead of hi/mq
            alu_a <= hi_nxt;
            alu_b <= mq_nxt[0] ? acc : '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a reference ALU and a response scoreboard.
// Expectations follow ALU_SEQ_MUL_EN when it is defined for the build.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_fs;
  logic [3:0] cmd_data;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_fs;
  logic       alu_c, alu_v, alu_n, alu_z;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [4:0] alu_t;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_fs(cmd_fs), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Reference ALU: carry out of add, borrow out of subtract
  always_comb begin
    alu_t = 5'd0;
    alu_v = 1'b0;
    case (alu_fs)
      3'b000: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[3] == alu_b[3]) && (alu_t[3] != alu_a[3]);
      end
      3'b001: begin
        alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_v = (alu_a[3] != alu_b[3]) && (alu_t[3] != alu_a[3]);
      end
      3'b010:  alu_t = {1'b0, alu_a & alu_b};
      3'b011:  alu_t = {1'b0, alu_a | alu_b};
      default: alu_t = {1'b0, alu_a ^ alu_b};
    endcase
    alu_y = alu_t[3:0];
    alu_c = alu_t[4];
    alu_n = alu_t[3];
    alu_z = (alu_t[3:0] == 4'h0);
  end

  typedef struct {
    logic [7:0] d;
    logic [3:0] f;
    logic       e;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_xfer = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: latency on first sight, stability while stalled, contents on transfer
  exp_t        cur;
  logic [12:0] hold;
  bit          in_rsp = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      chk("cmd_ready_in_resp", cmd_ready, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 1'b0);
      end else begin
        cur = sb[0];
        if (!in_rsp) begin
          chk("latency", cyc + 1, cur.due);
          hold   = {rsp_data, rsp_flags, rsp_err};
          in_rsp = 1'b1;
        end else begin
          chk("stall_stable", {rsp_data, rsp_flags, rsp_err}, hold);
        end
        if (rsp_ready) begin
          chk("rsp_data", rsp_data, cur.d);
          chk("rsp_flags", rsp_flags, cur.f);
          chk("rsp_err", rsp_err, cur.e);
          void'(sb.pop_front());
          in_rsp = 1'b0;
          n_xfer++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] fs, input logic [3:0] d,
                      input logic [7:0] ed, input logic [3:0] ef, input logic ee, input int lat);
    exp_t x;
    cmd_op    = op;
    cmd_fs    = fs;
    cmd_data  = d;
    cmd_valid = 1'b1;
    for (int k = 0; k < 100 && !cmd_ready; k++) tick();
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
    end else begin
      x.d = ed; x.f = ef; x.e = ee; x.due = cyc + 1 + lat;
      sb.push_back(x);
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 8'h00);
    chk({tag, "_rsp_flags"}, rsp_flags, 4'h0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_alu_ops"}, {alu_a, alu_b, alu_fs}, 11'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_fs = 3'b000; cmd_data = 4'h0; rsp_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", cmd_ready, 1'b1);

    send(OP_LOAD, FS_ADD, 4'h5, 8'h05, 4'b0000, 1'b0, 1); drain();
    send(OP_LOAD, FS_ADD, 4'h7, 8'h07, 4'b0000, 1'b0, 1); drain();
    send(OP_EXEC, FS_ADD, 4'h1, 8'h08, 4'b0110, 1'b0, 2); drain();
    send(OP_EXEC, FS_SUB, 4'h8, 8'h00, 4'b0001, 1'b0, 2); drain();
    send(OP_CLR,  FS_ADD, 4'h9, 8'h00, 4'b0001, 1'b0, 1); drain();
    send(OP_LOAD, FS_ADD, 4'hF, 8'h0F, 4'b0010, 1'b0, 1); drain();
    send(OP_EXEC, FS_ADD, 4'h1, 8'h00, 4'b1001, 1'b0, 2); drain();
    send(OP_LOAD, FS_ADD, 4'h3, 8'h03, 4'b0000, 1'b0, 1); drain();
    send(OP_EXEC, FS_SUB, 4'h5, 8'h0E, 4'b1010, 1'b0, 2); drain();

    // Multiply cases, then read the accumulator back through EXEC ADD 0
    send(OP_LOAD, FS_ADD, 4'hF, 8'h0F, 4'b0010, 1'b0, 1); drain();
    if (MUL_ON) send(OP_MUL, FS_ADD, 4'hF, 8'hE1, 4'b0010, 1'b0, 5);
    else        send(OP_MUL, FS_ADD, 4'hF, 8'h0F, 4'b0010, 1'b1, 1);
    drain();
    if (MUL_ON) send(OP_EXEC, FS_ADD, 4'h0, 8'h01, 4'b0000, 1'b0, 2);
    else        send(OP_EXEC, FS_ADD, 4'h0, 8'h0F, 4'b0010, 1'b0, 2);
    drain();
    send(OP_LOAD, FS_ADD, 4'h5, 8'h05, 4'b0000, 1'b0, 1); drain();
    if (MUL_ON) send(OP_MUL, FS_ADD, 4'h3, 8'h0F, 4'b0000, 1'b0, 5);
    else        send(OP_MUL, FS_ADD, 4'h3, 8'h05, 4'b0000, 1'b1, 1);
    drain();
    send(OP_LOAD, FS_ADD, 4'h9, 8'h09, 4'b0010, 1'b0, 1); drain();
    if (MUL_ON) send(OP_MUL, FS_ADD, 4'h0, 8'h00, 4'b0001, 1'b0, 5);
    else        send(OP_MUL, FS_ADD, 4'h0, 8'h09, 4'b0010, 1'b1, 1);
    drain();

    // Response held off for a dozen cycles
    xfer0 = n_xfer;
    rsp_ready = 1'b0;
    send(OP_LOAD, FS_ADD, 4'hA, 8'h0A, 4'b0010, 1'b0, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("stall_cmd_ready", cmd_ready, 1'b0);
      chk("stall_rsp_valid", rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    drain();
    tick();
    chk("stall_single_xfer", n_xfer - xfer0, 1);
    chk("stall_valid_drop", rsp_valid, 1'b0);

    // Reset two cycles into a MUL (iteration 2, or stalled RESP without MUL)
    send(OP_LOAD, FS_ADD, 4'h3, 8'h03, 4'b0000, 1'b0, 1); drain();
    rsp_ready = 1'b0;
    send(OP_MUL, FS_ADD, 4'h7, 8'h15, 4'b0000, !MUL_ON, MUL_ON ? 5 : 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    sb.delete();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 1'b0);
    end
    send(OP_LOAD, FS_ADD, 4'h6, 8'h06, 4'b0000, 1'b0, 1); drain();
    send(OP_EXEC, FS_ADD, 4'h2, 8'h08, 4'b0110, 1'b0, 2); drain();

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
